// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: OPB register front end that queues CPU transmit words,
// launches one SPI master transfer per queued word and collects the master
// and slave receive words into separate registers with sticky status flags.
module spi_xfer_sequencer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h8000,
  parameter int          TIMEOUT    = 1024,
  parameter logic [7:0]  DIV_RESET  = 8'd4
) (
  input  logic        opb_clk,
  input  logic        reset,
  input  logic        opb_select,
  input  logic        opb_rnw,
  input  logic [15:0] opb_abus,
  input  logic [31:0] opb_dbus,
  output logic [31:0] sl_dbus,
  output logic        sl_xferack,
  output logic        m_start,
  output logic [31:0] m_txdata,
  output logic [7:0]  m_div,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic [31:0] m_rxdata,
  input  logic        s_valid,
  input  logic [31:0] s_rxdata,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  // The abort fires on the cycle whose increment would bring the counter to
  // TIMEOUT-1, so LAUNCH plus WAIT_DONE spans exactly TIMEOUT cycles.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_cnt;
  logic          r_start;
  logic [31:0]   r_txData;
  logic          r_ack;
  logic [31:0]   r_dbus;
  logic          r_enable;
  logic          r_irqEn;
  logic [7:0]    r_div;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_rxData;
  logic [31:0]   r_slvData;
  logic          r_mrx;
  logic          r_srx;
  logic          r_tout;
  logic          r_ovf;
  logic          r_sovf;
  logic          r_irq;

  logic [15:0] w_off;
  logic        w_inRange;
  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_idx;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_doneEvt;
  logic        w_toutEvt;
  logic        w_busy;
  logic [4:0]  w_count5;
  logic [31:0] w_status;
  logic [31:0] w_ctrl;
  logic [31:0] w_rdata;

  assign w_off     = opb_abus - BASE_ADDR;
  assign w_inRange = (opb_abus >= BASE_ADDR) && (w_off <= 16'h0013);
  assign w_hit     = opb_select && w_inRange && !r_ack;
  assign w_wr      = w_hit && !opb_rnw;
  assign w_rd      = w_hit && opb_rnw;
  assign w_idx     = w_off[4:2];

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = w_wr && (w_idx == 3'd0) && !w_full;
  assign w_pop     = (r_state == ST_IDLE) && r_enable && !w_empty && !m_busy;
  assign w_doneEvt = (r_state == ST_WAIT) && m_done;
  assign w_toutEvt = (r_state == ST_WAIT) && !m_done && (r_cnt == CNT_LAST);
  assign w_busy    = (r_state != ST_IDLE);

  assign w_count5  = 5'(r_count);
  assign w_status  = {19'd0, w_count5, 2'b00, r_sovf, r_ovf, r_tout, r_srx, r_mrx, w_busy};
  assign w_ctrl    = {16'd0, r_div, 6'd0, r_irqEn, r_enable};

  // Read multiplexer over the register offsets; TXDATA and holes read zero.
  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      3'd1:    w_rdata = r_rxData;
      3'd2:    w_rdata = r_slvData;
      3'd3:    w_rdata = w_status;
      3'd4:    w_rdata = w_ctrl;
      default: w_rdata = 32'd0;
    endcase
  end

  // One-cycle acknowledge; read data is only driven during the ack cycle of a read.
  always_ff @(posedge opb_clk or posedge reset) begin
    if (reset) begin
      r_ack  <= 1'b0;
      r_dbus <= 32'd0;
    end else begin
      r_ack  <= w_hit;
      r_dbus <= w_rd ? w_rdata : 32'd0;
    end
  end

  // CTRL register: enable, interrupt enable and SCLK divider.
  always_ff @(posedge opb_clk or posedge reset) begin
    if (reset) begin
      r_enable <= 1'b0;
      r_irqEn  <= 1'b0;
      r_div    <= DIV_RESET;
    end else if (w_wr && (w_idx == 3'd4)) begin
      r_enable <= opb_dbus[0];
      r_irqEn  <= opb_dbus[1];
      r_div    <= opb_dbus[15:8];
    end
  end

  // Transmit FIFO storage, written on every accepted TXDATA push.
  always_ff @(posedge opb_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (w_push) begin
      r_mem[r_wrPtr] <= opb_dbus;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth; simultaneous push and pop keep the count.
  always_ff @(posedge opb_clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Transfer sequencer: pop a word, pulse start, then wait for done or abort on timeout.
  always_ff @(posedge opb_clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_start  <= 1'b0;
      r_txData <= 32'd0;
      r_cnt    <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_txData <= r_mem[r_rdPtr];
            r_start  <= 1'b1;
            r_state  <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_doneEvt || w_toutEvt) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Receive registers and sticky status flags; a new event wins over a read-clear in the same cycle.
  always_ff @(posedge opb_clk or posedge reset) begin
    if (reset) begin
      r_rxData  <= 32'd0;
      r_slvData <= 32'd0;
      r_mrx     <= 1'b0;
      r_srx     <= 1'b0;
      r_tout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_sovf    <= 1'b0;
    end else begin
      if (w_doneEvt) begin
        r_rxData <= m_rxdata;
        r_mrx    <= 1'b1;
      end else if (w_rd && (w_idx == 3'd1)) begin
        r_mrx <= 1'b0;
      end

      if (s_valid) begin
        r_slvData <= s_rxdata;
        r_srx     <= 1'b1;
      end else if (w_rd && (w_idx == 3'd2)) begin
        r_srx <= 1'b0;
      end

      if (s_valid && r_srx)                  r_sovf <= 1'b1;
      else if (w_rd && (w_idx == 3'd3))      r_sovf <= 1'b0;

      if (w_toutEvt)                         r_tout <= 1'b1;
      else if (w_rd && (w_idx == 3'd3))      r_tout <= 1'b0;

      if (w_wr && (w_idx == 3'd0) && w_full) r_ovf <= 1'b1;
      else if (w_rd && (w_idx == 3'd3))      r_ovf <= 1'b0;
    end
  end

  // Level interrupt, registered one cycle behind the status flags.
  always_ff @(posedge opb_clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= r_irqEn && (r_mrx || r_srx || r_tout || r_ovf || r_sovf);
  end

  assign sl_dbus    = r_dbus;
  assign sl_xferack = r_ack;
  assign m_start    = r_start;
  assign m_txdata   = r_txData;
  assign m_div      = r_div;
  assign irq        = r_irq;

endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
- OPB-side controller that sequences the SPI master engine and collects slave-side receive words.
- Buffers CPU transmit words in a small FIFO and launches one 32-bit master transfer per entry via a start/busy/done handshake.
- Latches master and slave receive words into separate registers, so the two sources never share a read path.
- Answers OPB reads and writes with a single-cycle xferack and raises a level interrupt.

Parameters:
- FIFO_DEPTH, 4, transmit FIFO entries (power of two, 2..16).
- BASE_ADDR, 16'h8000, OPB base address; block decodes BASE_ADDR..BASE_ADDR+16'h13.
- TIMEOUT, 1024, opb_clk cycles allowed from start to done before abort.
- DIV_RESET, 8'd4, reset value of the SPI clock divider field.

Ports:
- opb_clk  in  1  sole clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- opb_select  in  1  OPB slave select.
- opb_rnw  in  1  1 = read, 0 = write.
- opb_abus  in  16  byte address.
- opb_dbus  in  32  write data.
- sl_dbus  out  32  read data; zero except in the xferack cycle of a read.
- sl_xferack  out  1  one-cycle transfer acknowledge.
- m_start  out  1  one-cycle launch pulse to the master engine.
- m_txdata  out  32  word for the master engine; stable from m_start until m_done.
- m_div  out  8  SCLK divider to the master engine.
- m_busy  in  1  master engine busy.
- m_done  in  1  one-cycle pulse: transfer complete, m_rxdata valid.
- m_rxdata  in  32  master receive word.
- s_valid  in  1  one-cycle pulse: slave receive word complete.
- s_rxdata  in  32  slave receive word.
- irq  out  1  level interrupt.

Behaviour:
- Reset values:
  - sl_dbus=0, sl_xferack=0, m_start=0, m_txdata=0, m_div=DIV_RESET, irq=0.
  - FIFO empty; RXDATA=0, SLVDATA=0, STATUS=0, CTRL enable=0, irq_en=0.
  - FSM in IDLE.
- Reset asserted mid-transfer: FSM returns to IDLE immediately and m_start deasserts. Any m_done arriving after reset release while in IDLE is ignored.
- Decode: access when opb_select=1, address in range, and sl_xferack=0 in the current cycle.
  - sl_xferack asserts the following cycle for exactly one cycle.
  - Register side effects take place at that ack edge.
  - Out-of-range addresses get no ack.
- Register map (offset):
  - 0x00 TXDATA: write only; pushes opb_dbus.
    - If the FIFO is full, the write is acked and dropped, and STATUS.ovf (bit 4) is set.
    - A read returns 0.
  - 0x04 RXDATA: read only; last m_rxdata. Reading clears STATUS.mrx (bit 1).
  - 0x08 SLVDATA: read only; last s_rxdata. Reading clears STATUS.srx (bit 2).
  - 0x0C STATUS: read only.
    - Fields: bit0 busy (FSM not IDLE), bit1 mrx, bit2 srx, bit3 tout, bit4 ovf, bit5 sovf, bits[12:8] FIFO count.
    - Reading clears tout, ovf and sovf.
  - 0x10 CTRL: read/write; bit0 enable, bit1 irq_en, bits[15:8] div (mirrors m_div). Other bits read 0.
- s_valid: loads SLVDATA and sets srx. If srx is already set, sovf is also set and SLVDATA is overwritten.
- s_valid in the same cycle as a SLVDATA read ack: the new word wins and srx remains 1.
- FSM:
  - IDLE: if enable=1, FIFO not empty and m_busy=0, pop the head into m_txdata and go to LAUNCH.
  - LAUNCH: m_start=1 for one cycle; go to WAIT_DONE and clear the timeout counter.
  - WAIT_DONE: counter increments each cycle.
    - On m_done: load RXDATA, set mrx, go to IDLE.
    - If the counter reaches TIMEOUT-1 without m_done: set tout and go to IDLE. The popped word is lost.
- A push and a pop in the same cycle are both honoured; count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; the count is held in log2(FIFO_DEPTH)+1 bits.
- Clearing enable mid-transfer does not abort the transfer; it only blocks the next launch.
- irq = irq_en & (mrx | srx | tout | ovf | sovf), registered, one cycle after the status change.
- Minimum back-to-back spacing: consecutive m_start pulses are at least 3 cycles apart.

Test Plan:
- Reset:
  - Stimulus: assert reset for 3 cycles, release, then read 0x0C and 0x10.
  - Required: STATUS reads 0; CTRL reads 16'h0400 (div=4); each read acked exactly one cycle after select.
- Single transfer:
  - Stimulus: write CTRL=32'h00000803, then write TXDATA=32'hA5A5_1234. Model m_done 40 cycles after m_start with m_rxdata=32'hDEAD_BEEF.
  - Required: m_div=8; m_start pulses once with m_txdata=32'hA5A5_1234; irq rises; RXDATA reads 32'hDEAD_BEEF; mrx clears after the read.
- FIFO overflow:
  - Stimulus: enable=0, write TXDATA five times (1..5).
  - Required: STATUS count=4, ovf=1. After setting enable, exactly four m_start pulses with data 1,2,3,4 in order.
- Timeout:
  - Stimulus: TIMEOUT=1024, one word queued, m_done never pulses.
  - Required: FSM returns to IDLE 1024 cycles after m_start; tout=1; a STATUS read clears tout and irq drops.
- Slave double receive:
  - Stimulus: s_valid with 32'h1111_1111, then s_valid with 32'h2222_2222 before any read.
  - Required: SLVDATA reads 32'h2222_2222; STATUS shows srx=1 and sovf=1.
- Reset mid-transfer:
  - Stimulus: assert reset in WAIT_DONE, then pulse m_done after release.
  - Required: no RXDATA update, FIFO empty, m_start stays low.
